// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshake; `ALU_SEQ_MULDIV_EN adds iterative MUL/MULHU/DIVU/REMU.
// Without the macro, codes 1001/1010/1101/1111 complete in one cycle with aluRes=0, zero=1.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       aluCtr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluRes,
  output logic             zero
);
  localparam int SHW = $clog2(WIDTH);
`ifdef ALU_SEQ_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif
  state_t state, nstate;
  logic accept, load;
  logic [SHW-1:0] sh;
  logic [WIDTH-1:0] basic, res;
  assign accept = in_valid && in_ready;
  assign sh = input1[SHW-1:0];
  always_comb begin
    case (aluCtr)
      4'b0000: basic = input1 & input2;
      4'b0001: basic = input1 | input2;
      4'b0010: basic = input1 + input2;
      4'b0011: basic = input2 << sh;
      4'b0100: basic = input2 >> sh;
      4'b0101: basic = input1;
      4'b0110: basic = input1 - input2;
      4'b0111: basic = WIDTH'($signed(input1) < $signed(input2));
      4'b1000: basic = WIDTH'(input1 < input2);
      4'b1011: basic = input1 ^ input2;
      4'b1100: basic = ~(input1 | input2);
      4'b1110: basic = $signed(input2) >>> sh;
      default: basic = '0;
    endcase
  end
`ifdef ALU_SEQ_MULDIV_EN
  // hi:lo is the product (shifting right) or remainder:quotient (shifting left); opb is multiplicand/divisor
  logic [3:0] op;
  logic [WIDTH-1:0] hi, lo, opb, nhi, nlo, rdiff;
  logic [WIDTH:0] madd, rsh;
  logic [SHW-1:0] cnt;
  logic is_md, is_div, rge, last;
  assign is_md = aluCtr inside {4'b1001, 4'b1010, 4'b1101, 4'b1111};
  assign is_div = op inside {4'b1010, 4'b1101};
  assign last = cnt == SHW'(WIDTH - 1);
  assign madd = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
  assign rsh = {hi, lo[WIDTH-1]};
  assign rge = rsh >= {1'b0, opb};
  assign rdiff = rsh[WIDTH-1:0] - opb;
  assign nhi = is_div ? (rge ? rdiff : rsh[WIDTH-1:0]) : madd[WIDTH:1];
  assign nlo = is_div ? {lo[WIDTH-2:0], rge} : {madd[0], lo[WIDTH-1:1]};
  assign load = (accept && !is_md) || (state == BUSY && last);
  assign res = state == BUSY ? (op inside {4'b1111, 4'b1101} ? nhi : nlo) : basic;
  always_ff @(posedge clk) begin
    if (reset) begin
      op <= '0;
      hi <= '0;
      lo <= '0;
      opb <= '0;
      cnt <= '0;
    end else if (accept) begin
      op <= aluCtr;
      hi <= '0;
      lo <= input1;
      opb <= input2;
      cnt <= '0;
    end else if (state == BUSY) begin
      hi <= nhi;
      lo <= nlo;
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign load = accept;
  assign res = basic;
`endif
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nstate;
  end
  always_comb begin
    nstate = state;
    case (state)
`ifdef ALU_SEQ_MULDIV_EN
      IDLE: nstate = accept ? (is_md ? BUSY : DONE) : IDLE;
      BUSY: nstate = last ? DONE : BUSY;
`else
      IDLE: nstate = accept ? DONE : IDLE;
`endif
      DONE: nstate = out_ready ? IDLE : DONE;
      default: nstate = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      aluRes <= '0;
      zero <= 1'b1;
    end else if (load) begin
      aluRes <= res;
      zero <= res == '0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with a scoreboard queue; a negedge monitor checks each accepted result.
module tb_alu_seq;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int MDLAT = MD ? 33 : 1;
  typedef struct {
    string nm;
    logic [31:0] r;
    logic z;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] input1 = '0, input2 = '0;
  logic [3:0] aluCtr = '0;
  logic in_ready, out_valid, zero;
  logic [31:0] aluRes;
  exp_t q[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input1(input1), .input2(input2), .aluCtr(aluCtr),
    .out_valid(out_valid), .out_ready(out_ready), .aluRes(aluRes), .zero(zero)
  );
  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask
  function automatic logic [31:0] md(logic [31:0] v);
    return MD ? v : 32'h0;
  endfunction
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h want none", aluRes);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_res"}, aluRes, e.r);
        chk({e.nm, "_zero"}, 32'(zero), 32'(e.z));
      end
    end
  end
  task automatic run(string nm, logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [31:0] r, int lat);
    int n, ok;
    aluCtr = c;
    input1 = a;
    input2 = b;
    in_valid = 1'b1;
    q.push_back('{nm, r, r == 32'h0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    input1 = $urandom;
    input2 = $urandom;
    aluCtr = 4'($urandom);
    n = 1;
    ok = 1;
    while (!out_valid && n < 100) begin
      if (in_ready) ok = 0;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    if (lat > 1) chk({nm, "_busy_ready"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int ok;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_res", aluRes, 32'h0);
    chk("rst_zero", 32'(zero), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    run("add", 4'b0010, 32'd5, 32'd7, 32'd12, 1);
    run("sub", 4'b0110, 32'd9, 32'd9, 32'd0, 1);
    run("sra", 4'b1110, 32'h24, 32'h8000_0000, 32'hF800_0000, 1);
    run("and", 4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 1);
    run("or", 4'b0001, 32'hF0F0, 32'h0F00, 32'hFFF0, 1);
    run("sll", 4'b0011, 32'h21, 32'h4000_0001, 32'h8000_0002, 1);
    run("srl", 4'b0100, 32'd4, 32'h8000_0000, 32'h0800_0000, 1);
    run("pass", 4'b0101, 32'hDEAD_BEEF, 32'h1234, 32'hDEAD_BEEF, 1);
    run("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run("sltu", 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run("xor", 4'b1011, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1);
    run("nor", 4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF, 1);
    run("mul", 4'b1001, 32'hFFFF_FFFF, 32'd3, md(32'hFFFF_FFFD), MDLAT);
    run("mulhu", 4'b1111, 32'hFFFF_FFFF, 32'd3, md(32'd2), MDLAT);
    run("divu", 4'b1010, 32'd100, 32'd7, md(32'd14), MDLAT);
    run("remu", 4'b1101, 32'd100, 32'd7, md(32'd2), MDLAT);
    run("divu0", 4'b1010, 32'd5, 32'd0, md(32'hFFFF_FFFF), MDLAT);
    run("remu0", 4'b1101, 32'd5, 32'd0, md(32'd5), MDLAT);
    out_ready = 1'b0;
    aluCtr = 4'b0010;
    input1 = 32'd1;
    input2 = 32'd1;
    in_valid = 1'b1;
    q.push_back('{"hold", 32'd2, 1'b0});
    @(posedge clk); #1;
    aluCtr = 4'b0110;
    input1 = 32'd7;
    input2 = 32'd3;
    ok = 1;
    repeat (5) begin
      if (!out_valid || aluRes !== 32'd2 || in_ready) ok = 0;
      @(posedge clk); #1;
    end
    chk("hold_stable", 32'(ok), 32'd1);
    chk("hold_res", aluRes, 32'd2);
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    aluCtr = 4'b1010;
    input1 = 32'd100;
    input2 = 32'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_res", aluRes, 32'h0);
    chk("midrst_zero", 32'(zero), 32'd1);
    out_ready = 1'b1;
    run("mul34", 4'b1001, 32'd3, 32'd4, md(32'd12), MDLAT);
    run("add_after", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
